// File: rtl/axi_burst_adapter_pkg.sv
// Shared encodings for the AXI burst adapter: AXI burst/size/resp codes,
// fixed attribute values and the controller state type.
package axi_burst_adapter_pkg;

  typedef logic [1:0] axi_burst_t;
  typedef logic [2:0] axi_size_t;
  typedef logic [1:0] axi_resp_t;

  // Burst type
  localparam axi_burst_t BurstFixed = 2'b00;
  localparam axi_burst_t BurstIncr  = 2'b01;
  localparam axi_burst_t BurstWrap  = 2'b10;

  // Beat size (bytes per beat = 2**size)
  localparam axi_size_t Size1B = 3'b000;
  localparam axi_size_t Size2B = 3'b001;
  localparam axi_size_t Size4B = 3'b010;
  localparam axi_size_t Size8B = 3'b011;

  // Response codes
  localparam axi_resp_t RespOkay   = 2'b00;
  localparam axi_resp_t RespExokay = 2'b01;
  localparam axi_resp_t RespSlverr = 2'b10;
  localparam axi_resp_t RespDecerr = 2'b11;

  // Fixed transaction attributes
  localparam logic [1:0] LockNormal = 2'b00;
  localparam logic [3:0] CacheNone  = 4'b0000;
  localparam logic [2:0] ProtNone   = 3'b000;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRaddr = 3'd1,
    StRdata = 3'd2,
    StWaddr = 3'd3,
    StWdata = 3'd4,
    StWresp = 3'd5
  } state_e;

  // Limit a requested beats-1 value to the configured maximum.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_m1);
    return (len > max_m1) ? max_m1 : len;
  endfunction

  // SLVERR and DECERR both have bit 1 set.
  function automatic logic resp_is_err(input axi_resp_t resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_burst_adapter_if.sv
// AXI3 master bus bundle (AR, R, AW, W, B channels).
// Modports: master (adapter side), slave (memory/interconnect side).
interface axi_burst_adapter_if
  import axi_burst_adapter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  // Read address
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arlen;
  axi_size_t             arsize;
  axi_burst_t            arburst;
  logic [1:0]            arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  // Read data
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  axi_resp_t             rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  // Write address
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [3:0]            awlen;
  axi_size_t             awsize;
  axi_burst_t            awburst;
  logic [1:0]            awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  // Write data
  logic [ID_WIDTH-1:0]   wid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  // Write response
  logic [ID_WIDTH-1:0]   bid;
  axi_resp_t             bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the read and write data phases.
// Ports: clk, rst (async active-low), load (clear count, capture len),
//        len (beats-1), incr (one beat transferred), last (count == len).
module axi_beat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] len,
  input  logic       incr,
  output logic       last
);

  logic [3:0] cnt_q;
  logic [3:0] len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      len_q <= len;
    end else if (incr) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign last = (cnt_q == len_q);

endmodule

// File: rtl/axi_burst_adapter.sv
// Converts simple single-request bursts into AXI3 INCR transactions.
// Ports: clk, rst (async active-low);
//        req_* : request handshake (write flag, addr, size, len=beats-1, wstrb);
//        wbeat_data/wbeat_ready : show-ahead write data source and its pop strobe;
//        rbeat_* : registered read beats; resp_valid/resp_err : completion pulse;
//        axi : AXI3 master bus.
module axi_burst_adapter
  import axi_burst_adapter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // Request
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2:0]              req_size,
  input  logic [3:0]              req_len,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  // Write beats
  input  logic [DATA_WIDTH-1:0]   wbeat_data,
  output logic                    wbeat_ready,
  // Read beats
  output logic                    rbeat_valid,
  output logic [DATA_WIDTH-1:0]   rbeat_data,
  output logic                    rbeat_last,
  // Completion
  output logic                    resp_valid,
  output logic                    resp_err,
  // AXI3 master
  axi_burst_adapter_if.master     axi
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [ID_WIDTH-1:0] AxiId = ID_WIDTH'(AXI_ID);
  localparam logic [3:0] MaxLenM1 = 4'(MAX_LEN - 1);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic [3:0]            len_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  err_q, err_d;

  logic                  rbeat_valid_q, rbeat_valid_d;
  logic [DATA_WIDTH-1:0] rbeat_data_q, rbeat_data_d;
  logic                  rbeat_last_q, rbeat_last_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;

  logic       accept;
  logic       ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic       r_beat_err, b_err;
  logic [3:0] len_clamped;
  logic       cnt_last;

  assign accept      = req_valid && (state_q == StIdle);
  assign ar_hs       = (state_q == StRaddr) && axi.arready;
  assign aw_hs       = (state_q == StWaddr) && axi.awready;
  // rvalid/bvalid only count in the phases that expect them.
  assign r_hs        = (state_q == StRdata) && axi.rvalid;
  assign w_hs        = (state_q == StWdata) && axi.wready;
  assign b_hs        = (state_q == StWresp) && axi.bvalid;
  assign r_beat_err  = resp_is_err(axi.rresp) || (axi.rid != AxiId);
  assign b_err       = resp_is_err(axi.bresp) || (axi.bid != AxiId);
  assign len_clamped = clamp_len(req_len, MaxLenM1);

  axi_beat_counter u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .len  (len_clamped),
    .incr (r_hs || w_hs),
    .last (cnt_last)
  );

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = req_write ? StWaddr : StRaddr;
      StRaddr: if (ar_hs) state_d = StRdata;
      StRdata: if (r_hs && axi.rlast) state_d = StIdle;
      StWaddr: if (aw_hs) state_d = StWdata;
      StWdata: if (w_hs && cnt_last) state_d = StWresp;
      StWresp: if (b_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read beat forwarding and completion
  always_comb begin
    err_d         = err_q;
    rbeat_valid_d = r_hs;
    rbeat_data_d  = rbeat_data_q;
    rbeat_last_d  = r_hs && axi.rlast;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    if (accept) begin
      err_d = 1'b0;
    end else if (r_hs) begin
      err_d = err_q || r_beat_err;
    end
    if (r_hs) begin
      rbeat_data_d = axi.rdata;
    end
    // Read completion coincides with the forwarded last beat.
    if (r_hs && axi.rlast) begin
      resp_valid_d = 1'b1;
      resp_err_d   = err_q || r_beat_err;
    end else if (b_hs) begin
      resp_valid_d = 1'b1;
      resp_err_d   = b_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      size_q        <= '0;
      len_q         <= '0;
      wstrb_q       <= '0;
      err_q         <= 1'b0;
      rbeat_valid_q <= 1'b0;
      rbeat_data_q  <= '0;
      rbeat_last_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      rbeat_valid_q <= rbeat_valid_d;
      rbeat_data_q  <= rbeat_data_d;
      rbeat_last_q  <= rbeat_last_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        len_q   <= len_clamped;
        wstrb_q <= req_wstrb;
      end
    end
  end

  // Request / local outputs
  assign req_ready   = (state_q == StIdle);
  assign wbeat_ready = w_hs;
  assign rbeat_valid = rbeat_valid_q;
  assign rbeat_data  = rbeat_data_q;
  assign rbeat_last  = rbeat_last_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;

  // AR / R
  assign axi.arid    = AxiId;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = BurstIncr;
  assign axi.arlock  = LockNormal;
  assign axi.arcache = CacheNone;
  assign axi.arprot  = ProtNone;
  assign axi.arvalid = (state_q == StRaddr);
  assign axi.rready  = (state_q == StRdata);

  // AW / W / B
  assign axi.awid    = AxiId;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = BurstIncr;
  assign axi.awlock  = LockNormal;
  assign axi.awcache = CacheNone;
  assign axi.awprot  = ProtNone;
  assign axi.awvalid = (state_q == StWaddr);
  assign axi.wid     = AxiId;
  assign axi.wdata   = wbeat_data;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = cnt_last;
  assign axi.wvalid  = (state_q == StWdata);
  assign axi.bready  = (state_q == StWresp);

  // Only bit 1 of a response carries the error indication.
  logic unused_resp_lsb;
  assign unused_resp_lsb = axi.rresp[0] ^ axi.bresp[0];

endmodule

// File: tb/tb_axi_burst_adapter.sv
module tb_axi_burst_adapter;
  import axi_burst_adapter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = DW / 8;
  localparam logic [IW-1:0] Id = 4'h3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_size;
  logic [3:0]    req_len;
  logic [SW-1:0] req_wstrb;
  logic [DW-1:0] wbeat_data;
  logic          wbeat_ready;
  logic          rbeat_valid, rbeat_last;
  logic [DW-1:0] rbeat_data;
  logic          resp_valid, resp_err;

  axi_burst_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_burst_adapter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .AXI_ID     (3),
    .MAX_LEN    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_len     (req_len),
    .req_wstrb   (req_wstrb),
    .wbeat_data  (wbeat_data),
    .wbeat_ready (wbeat_ready),
    .rbeat_valid (rbeat_valid),
    .rbeat_data  (rbeat_data),
    .rbeat_last  (rbeat_last),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .axi         (bus.master)
  );

  int vectors = 0;
  int miscompares = 0;
  int rbeat_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {logic last; logic [DW-1:0] data;} rbeat_t;
  typedef struct {logic is_read; logic err;} resp_t;
  rbeat_t rq[$];
  resp_t  respq[$];
  rbeat_t mon_rb;
  resp_t  mon_rs;

  // Output monitor: read beats and completions against the scoreboard.
  always @(negedge clk) begin
    if (rbeat_valid) begin
      rbeat_count++;
      if (rq.size() == 0) begin
        check("rbeat_unexpected", 1, 0);
      end else begin
        mon_rb = rq.pop_front();
        check("rbeat_data", rbeat_data, mon_rb.data);
        check("rbeat_last", rbeat_last, mon_rb.last);
      end
    end
    if (resp_valid) begin
      if (respq.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        mon_rs = respq.pop_front();
        check("resp_err", resp_err, mon_rs.err);
        if (mon_rs.is_read) check("resp_with_rlast", rbeat_valid && rbeat_last, 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) step();
    check("rq_empty", rq.size(), 0);
    check("respq_empty", respq.size(), 0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [3:0] len, input int ar_delay,
                         input logic [3:0] exp_len, input logic [15:0] slverr_mask,
                         input logic [DW-1:0] base);
    int   hi;
    int   start;
    logic err;
    hi = 0;
    err = 1'b0;
    start = rbeat_count;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    req_len   = len;
    req_size  = Size4B;
    check("req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i <= ar_delay; i++) begin
      if (bus.arvalid) hi++;
      if (i == ar_delay) begin
        bus.arready = 1'b1;
        check("araddr", bus.araddr, addr);
        check("arlen", bus.arlen, exp_len);
        check("arburst", bus.arburst, BurstIncr);
        check("arsize", bus.arsize, Size4B);
      end
      step();
    end
    bus.arready = 1'b0;
    check("arvalid_hold", hi, ar_delay + 1);
    check("arvalid_drop", bus.arvalid, 0);
    for (int b = 0; b <= int'(exp_len); b++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = base + DW'(b);
      bus.rid    = Id;
      bus.rresp  = slverr_mask[b] ? RespSlverr : RespOkay;
      bus.rlast  = (b == int'(exp_len));
      err = err | slverr_mask[b];
      rq.push_back('{last: (b == int'(exp_len)), data: base + DW'(b)});
      if (b == int'(exp_len)) respq.push_back('{is_read: 1'b1, err: err});
      check("rready", bus.rready, 1);
      step();
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    drain();
    check("rbeat_count", rbeat_count - start, int'(exp_len) + 1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [SW-1:0] strb, input bit toggle, input logic [1:0] bresp,
                          input logic [IW-1:0] bid, input int rst_beat,
                          input logic [DW-1:0] base);
    int idx;
    int pulses;
    int cyc;
    idx = 0;
    pulses = 0;
    cyc = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_len   = len;
    req_size  = Size4B;
    req_wstrb = strb;
    step();
    req_valid = 1'b0;
    check("awvalid", bus.awvalid, 1);
    check("awaddr", bus.awaddr, addr);
    check("awlen", bus.awlen, len);
    check("awburst", bus.awburst, BurstIncr);
    check("awid", bus.awid, Id);
    bus.awready = 1'b1;
    step();
    bus.awready = 1'b0;
    check("awvalid_drop", bus.awvalid, 0);
    while (idx <= int'(len) && cyc < 64) begin
      bus.wready = toggle ? (cyc % 2 == 0) : 1'b1;
      wbeat_data = base + DW'(idx);
      #1;
      check("wvalid", bus.wvalid, 1);
      if (rst_beat == idx) begin
        rst = 1'b0;
        #1;
        check("wvalid_async_rst", bus.wvalid, 0);
        check("rst_idle", req_ready, 1);
        bus.wready = 1'b0;
        step();
        rst = 1'b1;
        step();
        drain();
        return;
      end
      if (wbeat_ready) begin
        pulses++;
        check("wdata", bus.wdata, base + DW'(idx));
        check("wlast", bus.wlast, idx == int'(len));
        check("wstrb", bus.wstrb, strb);
        idx++;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    bus.wready = 1'b0;
    check("wbeat_pulses", pulses, int'(len) + 1);
    check("wvalid_done", bus.wvalid, 0);
    check("bready", bus.bready, 1);
    step();
    bus.bvalid = 1'b1;
    bus.bresp  = bresp;
    bus.bid    = bid;
    respq.push_back('{is_read: 1'b0, err: bresp[1] | (bid != Id)});
    step();
    bus.bvalid = 1'b0;
    check("bready_drop", bus.bready, 0);
    drain();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_size = '0;
    req_len = '0;
    req_wstrb = '0;
    wbeat_data = '0;
    bus.arready = 1'b0;
    bus.rid = '0;
    bus.rdata = '0;
    bus.rresp = RespOkay;
    bus.rlast = 1'b0;
    bus.rvalid = 1'b0;
    bus.awready = 1'b0;
    bus.wready = 1'b0;
    bus.bid = '0;
    bus.bresp = RespOkay;
    bus.bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_wvalid", bus.wvalid, 0);
    check("rst_rbeat_valid", rbeat_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    rst = 1'b1;
    step();

    // Stray responses while idle must be ignored.
    bus.rvalid = 1'b1;
    bus.rlast  = 1'b1;
    bus.bvalid = 1'b1;
    #1;
    check("idle_rready", bus.rready, 0);
    check("idle_bready", bus.bready, 0);
    step();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.bvalid = 1'b0;
    step();

    do_read(32'h1000, 4'd0, 3, 4'd0, 16'h0000, 32'hDEADBEEF);
    do_read(32'h2000, 4'd3, 0, 4'd3, 16'h0004, 32'h0000_0100);
    do_write(32'h3000, 4'd7, 4'hF, 1'b1, RespOkay, Id, -1, 32'hA000_0000);
    do_write(32'h4000, 4'd0, 4'b1100, 1'b0, RespDecerr, Id, -1, 32'hB000_0000);
    do_write(32'h5000, 4'd3, 4'hF, 1'b0, RespOkay, Id, 1, 32'hC000_0000);
    do_write(32'h5000, 4'd3, 4'hF, 1'b0, RespOkay, Id, -1, 32'hC100_0000);
    do_read(32'h6000, 4'd15, 1, 4'd7, 16'h0000, 32'h0000_0600);
    do_write(32'h7000, 4'd1, 4'h3, 1'b0, RespOkay, 4'h5, -1, 32'hD000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
